// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: round-robin sharing of one spi_master_driver among
// NUM_REQ requesters. A grant is held until the granted requester's last
// byte completes. For each byte the arbiter sequences the driver's
// start/ready handshake and returns the received byte.
// Optional build macro SPI_ARB_TIMEOUT_EN adds a per-byte watchdog with a
// sticky err_o. When the macro is undefined, err_o is tied to 0.
module spi_master_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_bi,
  input  logic [NUM_REQ-1:0]   last_bi,
  input  logic [8*NUM_REQ-1:0] tx_data_bi,
  output logic [NUM_REQ-1:0]   gnt_bo,
  output logic                 byte_ack_o,
  output logic                 rx_valid_o,
  output logic [7:0]           rx_data_bo,
  output logic                 busy_o,
  output logic                 err_o,
  output logic                 m_start_o,
  output logic [7:0]           m_data_bo,
  input  logic                 m_ready_i,
  input  logic [7:0]           m_data_bi
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_ACK,
    WAIT_DONE,
    NEXT
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [7:0]         data_q, data_d;
  logic               last_q, last_d;
  logic               rx_valid_q, rx_valid_d;
  logic [7:0]         rx_data_q, rx_data_d;

  logic [7:0]         tx_arr [NUM_REQ];
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   rr_cand;
  logic [IDX_W-1:0]   ptr_after;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // Unflatten the per-requester TX bytes.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_tx
    assign tx_arr[g] = tx_data_bi[8*g +: 8];
  end

  // Pick the first request at or after the pointer, with wrap-around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    rr_cand    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rr_cand = IDX_W'((32'(ptr_q) + i) % NUM_REQ);
      if (!pick_found && req_bi[rr_cand]) begin
        pick_found = 1'b1;
        pick_idx   = rr_cand;
      end
    end
  end

  // The pointer moves to the requester after the one being released.
  always_comb begin
    ptr_after = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
  end

  // Next-state logic and register updates for the arbiter FSM.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    idx_d      = idx_q;
    ptr_d      = ptr_q;
    data_d     = data_q;
    last_d     = last_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
`ifdef SPI_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        // m_ready_i must be high before granting. This also covers the
        // wait for the driver to recover after a watchdog abort.
        if (pick_found && m_ready_i) begin
          gnt_d   = NUM_REQ'(1) << pick_idx;
          idx_d   = pick_idx;
          data_d  = tx_arr[pick_idx];
          state_d = START;
        end
      end
      START: begin
        last_d  = last_bi[idx_q];
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (!m_ready_i) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (m_ready_i) begin
          rx_data_d  = m_data_bi;
          rx_valid_d = 1'b1;
          state_d    = NEXT;
        end
      end
      NEXT: begin
        if (!last_q && req_bi[idx_q]) begin
          data_d  = tx_arr[idx_q];
          state_d = START;
        end else begin
          gnt_d   = '0;
          ptr_d   = ptr_after;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
`ifdef SPI_ARB_TIMEOUT_EN
    // The watchdog only fires on a cycle where the handshake made no
    // progress. A byte completing on the limit cycle therefore still counts.
    if (state_q == START) begin
      cnt_d = '0;
    end else if (state_q == WAIT_ACK || state_q == WAIT_DONE) begin
      if (state_d == state_q && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        err_d   = 1'b1;
        gnt_d   = '0;
        ptr_d   = ptr_after;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
`endif
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      idx_q      <= '0;
      ptr_q      <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      idx_q      <= idx_d;
      ptr_q      <= ptr_d;
      data_q     <= data_d;
      last_q     <= last_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign gnt_bo     = gnt_q;
  assign byte_ack_o = (state_q == START);
  assign m_start_o  = (state_q == START);
  assign m_data_bo  = data_q;
  assign rx_valid_o = rx_valid_q;
  assign rx_data_bo = rx_data_q;
  assign busy_o     = (state_q != IDLE);
`ifdef SPI_ARB_TIMEOUT_EN
  assign err_o      = err_q;
`else
  assign err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Scoreboard bench for spi_master_arbiter. The expected grant order and byte
// stream come from a round-robin model over per-requester transaction lists.
// A monitor pops the expectations as the DUT acknowledges and returns bytes.
`timescale 1ns/1ps
module tb_spi_master_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0, last = '0;
  logic [8*N-1:0] tx = '0;
  logic [N-1:0]   gnt;
  logic           byte_ack, rx_valid, busy, err, m_start, m_ready = 1'b1;
  logic [7:0]     rx_data, m_dout, m_din = '0;

  always #5 clk = ~clk;

  spi_master_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(64)) dut (
    .clk_i(clk), .rst_i(rst_n), .req_bi(req), .last_bi(last), .tx_data_bi(tx),
    .gnt_bo(gnt), .byte_ack_o(byte_ack), .rx_valid_o(rx_valid),
    .rx_data_bo(rx_data), .busy_o(busy), .err_o(err), .m_start_o(m_start),
    .m_data_bo(m_dout), .m_ready_i(m_ready), .m_data_bi(m_din)
  );

  typedef struct packed { logic [7:0] tx; logic last; logic eot; } ent_t;
  typedef struct packed { logic [31:0] idx; logic [7:0] tx; logic [7:0] rx; logic eot; } exp_t;

  ent_t rq [N][$];
  exp_t exp_q[$];
  exp_t rx_q[$];
  int checks = 0, errors = 0;
  int model_ptr = 0;
  bit rel_chk = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, want);
    end
  endtask

  // Driver model: drops ready after a start, then returns tx ^ 8'h33.
  int slv_st = 0, slv_cnt = 0, slv_hold = 0;
  bit stuck = 0;
  logic [7:0] cap;
  initial forever begin
    @(posedge clk); #1;
    if (!rst_n) begin
      m_ready = 1'b1;
      slv_st  = 0;
    end else begin
      case (slv_st)
        0: if (m_start) begin
          cap = m_dout;
          if (stuck) slv_st = 2;
          else begin
            m_ready = 1'b0;
            slv_cnt = (slv_hold != 0) ? slv_hold : int'($urandom_range(2, 5));
            slv_st  = 1;
          end
        end
        1: begin
          slv_cnt--;
          if (slv_cnt == 0) begin
            m_din   = cap ^ 8'h33;
            m_ready = 1'b1;
            slv_st  = 0;
          end
        end
        default: ;
      endcase
    end
  end

  // Requesters: present the head byte; consume it the cycle after byte_ack.
  bit pend = 0;
  int pend_k = 0;
  initial forever begin
    @(posedge clk); #1;
    if (!rst_n) pend = 0;
    else begin
      if (pend && rq[pend_k].size() > 0) void'(rq[pend_k].pop_front());
      pend   = byte_ack;
      pend_k = 0;
      for (int k = 0; k < N; k++) if (gnt[k]) pend_k = k;
    end
    for (int k = 0; k < N; k++) begin
      if (rq[k].size() > 0) begin
        req[k]       = 1'b1;
        last[k]      = rq[k][0].last;
        tx[8*k +: 8] = rq[k][0].tx;
      end else begin
        req[k]  = 1'b0;
        last[k] = 1'b0;
      end
    end
  end

  // Monitor: compares DUT outputs against the scoreboard queues.
  logic [N-1:0] prev_gnt = '0;
  bit prev_busy = 0;
  logic [7:0] prev_rx = '0;
  exp_t e;
  initial forever begin
    @(posedge clk); #1;
    if (!rst_n) begin
      rel_chk = 0; prev_busy = 0; prev_rx = '0;
      continue;
    end
    chk("gnt_onehot0", 32'(gnt & (gnt - 1'b1)), 0);
    chk("start_eq_ack", 32'(m_start), 32'(byte_ack));
`ifndef SPI_ARB_TIMEOUT_EN
    chk("err_tied0", 32'(err), 0);
`endif
    if (prev_busy && busy) chk("gnt_stable", 32'(gnt), 32'(prev_gnt));
    if (rel_chk) begin
      chk("release_gnt", 32'(gnt), 0);
      chk("release_busy", 32'(busy), 0);
      rel_chk = 0;
    end
    if (byte_ack) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack actual=ack gnt=%0h required=no_ack", gnt);
      end else begin
        e = exp_q.pop_front();
        chk("ack_gnt", 32'(gnt), 32'd1 << e.idx);
        chk("m_data", 32'(m_dout), 32'(e.tx));
        rx_q.push_back(e);
      end
    end
    if (rx_valid) begin
      checks++;
      if (rx_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rx actual=rx %0h required=no_rx", rx_data);
      end else begin
        e = rx_q.pop_front();
        chk("rx_data", 32'(rx_data), 32'(e.rx));
        chk("rx_gnt", 32'(gnt), 32'd1 << e.idx);
        if (e.eot) rel_chk = 1;
      end
    end else begin
      chk("rx_hold", 32'(rx_data), 32'(prev_rx));
    end
    prev_rx = rx_data; prev_busy = busy; prev_gnt = gnt;
  end

  task automatic add_txn(input int k, input int len, input logic [31:0] bytes, input bit drop);
    ent_t en;
    for (int i = 0; i < len; i++) begin
      en.tx   = bytes[8*i +: 8];
      en.eot  = (i == len - 1);
      en.last = en.eot && !drop;
      rq[k].push_back(en);
    end
  endtask

  // Round-robin reference: whole transactions in pointer order.
  task automatic build_model();
    ent_t cp [N][$];
    ent_t en;
    exp_t x;
    int k;
    for (int i = 0; i < N; i++) cp[i] = rq[i];
    forever begin
      k = -1;
      for (int i = 0; i < N; i++) begin
        int c = (model_ptr + i) % N;
        if (k < 0 && cp[c].size() > 0) k = c;
      end
      if (k < 0) break;
      do begin
        en    = cp[k].pop_front();
        x.idx = 32'(k); x.tx = en.tx; x.rx = en.tx ^ 8'h33; x.eot = en.eot;
        exp_q.push_back(x);
      end while (!en.eot);
      model_ptr = (k + 1) % N;
    end
  endtask

  task automatic wait_done(input string name);
    bit done = 0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge clk);
      done = !busy && !rel_chk && exp_q.size() == 0 && rx_q.size() == 0;
      for (int i = 0; i < N; i++) if (rq[i].size() > 0) done = 0;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s actual=pending exp=%0d rx=%0d required=drained", name, exp_q.size(), rx_q.size());
      exp_q.delete(); rx_q.delete();
      for (int i = 0; i < N; i++) rq[i].delete();
    end
  endtask

  task automatic run_batch(input string name);
    build_model();
    wait_done(name);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 0);
    chk({tag, "_ack"}, 32'(byte_ack), 0);
    chk({tag, "_rxv"}, 32'(rx_valid), 0);
    chk({tag, "_rxd"}, 32'(rx_data), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_start"}, 32'(m_start), 0);
    chk({tag, "_mdata"}, 32'(m_dout), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int ntx, len;
    bit seen;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    add_txn(0, 1, 32'h5A, 0);
    run_batch("single");
    add_txn(1, 3, 32'h332211, 0);
    run_batch("multi");
    add_txn(0, 1, 32'h01, 0); add_txn(0, 1, 32'h02, 0);
    add_txn(2, 1, 32'h03, 0); add_txn(2, 1, 32'h04, 0);
    run_batch("round_robin");
    add_txn(3, 1, 32'hC3, 1);
    run_batch("early_drop");

    for (int b = 0; b < 12; b++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          ntx = int'($urandom_range(1, 3));
          for (int t = 0; t < ntx; t++) begin
            len = int'($urandom_range(1, 3));
            add_txn(k, len, $urandom, (t == ntx - 1) && ($urandom_range(0, 2) == 0));
          end
        end
      end
      run_batch("random");
    end

    // Reset while the driver is mid-byte.
    slv_hold = 8;
    add_txn(1, 2, 32'hBEEF, 0);
    build_model();
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      seen = !m_ready;
    end
    chk("reset_mid_reached", 32'(seen), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    exp_q.delete(); rx_q.delete();
    for (int i = 0; i < N; i++) rq[i].delete();
    model_ptr = 0; slv_hold = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    add_txn(2, 1, 32'h7E, 0);
    run_batch("after_reset");

`ifdef SPI_ARB_TIMEOUT_EN
    stuck = 1;
    add_txn(0, 1, 32'h99, 0);
    build_model();
    repeat (30) @(negedge clk);
    chk("to_err_early", 32'(err), 0);
    chk("to_busy_early", 32'(busy), 1);
    repeat (50) @(negedge clk);
    chk("to_err", 32'(err), 1);
    chk("to_gnt", 32'(gnt), 0);
    chk("to_busy", 32'(busy), 0);
    chk("to_no_rx", 32'(rx_q.size()), 1);
    rx_q.delete();
    stuck = 0; slv_st = 0;
    add_txn(1, 1, 32'h42, 0);
    run_batch("after_timeout");
    chk("to_sticky", 32'(err), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
- Shares one spi_master_driver between NUM_REQ requesters with round-robin arbitration.
- Each requester issues a multi-byte transaction; the grant is held until that requester's last byte completes.
- Sequences the driver's start/ready handshake per byte and returns each received byte to the granted requester.
- Sits between the bus-side peripheral logic and spi_master_driver.

Parameters:
NUM_REQ, 4, number of requesters (2..8); IDX_W = max(1, clog2(NUM_REQ)) is derived internally
TIMEOUT_CYCLES, 4096, watchdog limit per byte, in clk_i cycles (used only with SPI_ARB_TIMEOUT_EN)

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-low reset
req_bi  in  NUM_REQ  per-requester transaction request, level
last_bi  in  NUM_REQ  per-requester flag: the current byte is the final byte of the transaction
tx_data_bi  in  8*NUM_REQ  per-requester TX byte, flattened; requester k uses bits [8k+7:8k]
gnt_bo  out  NUM_REQ  one-hot grant
byte_ack_o  out  1  1-cycle pulse: TX byte of the granted requester was consumed
rx_valid_o  out  1  1-cycle pulse: rx_data_bo valid for the granted requester
rx_data_bo  out  8  received byte
busy_o  out  1  a transaction is in progress
err_o  out  1  sticky timeout flag (driven 0 when the feature is compiled out)
m_start_o  out  1  to driver start_i
m_data_bo  out  8  to driver data_in_bi
m_ready_i  in  1  from driver ready_o
m_data_bi  in  8  from driver data_out_bo

Behaviour:
- Reset (rst_i=0, asynchronous): state IDLE. All outputs are 0: gnt_bo, byte_ack_o, rx_valid_o, rx_data_bo, busy_o, err_o, m_start_o, m_data_bo. Round-robin pointer = 0. Reset is honoured mid-transfer: the arbiter abandons the byte and does not wait for the driver.
- States: IDLE, START, WAIT_ACK, WAIT_DONE, NEXT.
- IDLE: when any req_bi is set and m_ready_i=1, grant the first set request at or after the pointer, searching upward with wrap-around. The grant registers next cycle; go to START; busy_o=1.
- If m_ready_i=0 in IDLE (driver not ready), hold IDLE and grant nothing.
- START, one cycle:
  - m_start_o=1.
  - m_data_bo = granted requester's tx byte, latched into a register.
  - byte_ack_o=1.
  - Latch last_bi of the granted requester.
  - Go to WAIT_ACK.
- WAIT_ACK: m_start_o=0. Wait for m_ready_i=0, then go to WAIT_DONE.
- WAIT_DONE: on m_ready_i rising back to 1:
  - rx_data_bo <= m_data_bi.
  - rx_valid_o pulses 1 cycle.
  - Go to NEXT.
- NEXT, evaluated one cycle after rx_valid_o:
  - If latched last=0 and the granted req is still 1: go to START with the same grant.
  - Otherwise: release the grant, set pointer = granted index + 1 (mod NUM_REQ), busy_o=0, go to IDLE.
- Back-to-back transactions: a new request is granted the first cycle after NEXT, i.e. one idle cycle between transactions.
- Grant stability: gnt_bo stays constant from grant to release. Changes to req_bi or last_bi by other requesters are ignored during this time.
- A requester dropping req mid-transaction: the in-flight byte completes, then the transaction ends in NEXT.
- Throughput: 3 arbiter cycles per byte plus the driver's transfer time.
- gnt_bo is always one-hot or zero. rx_data_bo holds its value between rx_valid_o pulses.

Optional Feature:
- Macro: SPI_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on START and increments in WAIT_ACK/WAIT_DONE.
  - On reaching TIMEOUT_CYCLES: set err_o (sticky until reset), suppress rx_valid_o, release the grant, advance the pointer, go to IDLE.
  - After an abort, IDLE additionally waits for m_ready_i=1 before granting.
- Without the macro: no counter; err_o is tied to 0; the arbiter waits indefinitely.

Test Plan:
- Single requester: req0=1, last0=1, tx=8'h5A, slave returns 8'h69 -> exactly one m_start_o pulse with m_data_bo=8'h5A; rx_valid_o with rx_data_bo=8'h69; gnt_bo returns to 0; busy_o=0.
- Multi-byte: req1 sends 8'h11, 8'h22, 8'h33 with last on the third byte -> 3 byte_ack_o pulses; gnt_bo=4'b0010 held throughout; received bytes match the slave pattern in order.
- Round-robin: req0 and req2 set continuously, 1-byte transactions -> grant sequence 0, 2, 0, 2; no requester starved.
- Early drop: req3 drops req after its first byte with last=0 -> second byte is not started; grant is released after the first rx_valid_o.
- Reset mid-byte: assert rst_i=0 during WAIT_DONE -> all outputs 0 immediately; after release, a new request completes normally.
- Timeout (with SPI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=64): hold m_ready_i=1 after start -> at cycle 64, err_o=1, no rx_valid_o, grant released.
